// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings and widths for the pipeline hazard controller
package hazard_pkg;
  localparam int REG_W = 3;
  localparam logic [REG_W-1:0] ZERO_REG = '0;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;
endpackage

// File: rtl/haz_reg_match.sv
// haz_reg_match: flags a live source/destination register match, never for r0
module haz_reg_match
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             src_used,
  input  logic [REG_W-1:0] dst,
  input  logic             dst_write,
  output logic             match
);
  assign match = src_used & dst_write & (src == dst) & (src != ZERO_REG);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control and halt-drain sequencing; HAZ_FORWARD_EN enables forwarding
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] exe_rs,
  input  logic [REG_W-1:0] exe_rt,
  input  logic [REG_W-1:0] exe_rd,
  input  logic             exe_reg_write,
  input  logic             exe_mem_read,
  input  logic             exe_branch_taken,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_exe_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             halted
);
  state_t     state;
  logic [2:0] cnt;
  logic       m_rs_exe, m_rt_exe, m_rs_mem, m_rt_mem;
  logic       m_a_mem, m_a_wb, m_b_mem, m_b_wb;
  logic       stall, stall_eff;

  haz_reg_match u_rs_exe (.src(id_rs), .src_used(id_rs_used), .dst(exe_rd), .dst_write(exe_reg_write), .match(m_rs_exe));
  haz_reg_match u_rt_exe (.src(id_rt), .src_used(id_rt_used), .dst(exe_rd), .dst_write(exe_reg_write), .match(m_rt_exe));
  haz_reg_match u_rs_mem (.src(id_rs), .src_used(id_rs_used), .dst(mem_rd), .dst_write(mem_reg_write), .match(m_rs_mem));
  haz_reg_match u_rt_mem (.src(id_rt), .src_used(id_rt_used), .dst(mem_rd), .dst_write(mem_reg_write), .match(m_rt_mem));
  haz_reg_match u_a_mem  (.src(exe_rs), .src_used(1'b1), .dst(mem_rd), .dst_write(mem_reg_write), .match(m_a_mem));
  haz_reg_match u_a_wb   (.src(exe_rs), .src_used(1'b1), .dst(wb_rd), .dst_write(wb_reg_write), .match(m_a_wb));
  haz_reg_match u_b_mem  (.src(exe_rt), .src_used(1'b1), .dst(mem_rd), .dst_write(mem_reg_write), .match(m_b_mem));
  haz_reg_match u_b_wb   (.src(exe_rt), .src_used(1'b1), .dst(wb_rd), .dst_write(wb_reg_write), .match(m_b_wb));

`ifdef HAZ_FORWARD_EN
  logic unused_nofwd;
  assign unused_nofwd = m_rs_mem ^ m_rt_mem;
  assign stall     = exe_mem_read & (m_rs_exe | m_rt_exe);
  assign fwd_a_sel = m_a_mem ? FWD_MEM : m_a_wb ? FWD_WB : FWD_REG;
  assign fwd_b_sel = m_b_mem ? FWD_MEM : m_b_wb ? FWD_WB : FWD_REG;
`else
  logic unused_fwd;
  assign unused_fwd = ^{exe_mem_read, m_a_mem, m_a_wb, m_b_mem, m_b_wb};
  assign stall     = m_rs_exe | m_rt_exe | m_rs_mem | m_rt_mem;
  assign fwd_a_sel = FWD_REG;
  assign fwd_b_sel = FWD_REG;
`endif

  // a taken branch discards the stalled ID instruction, so that cycle is not a stall
  assign stall_eff = stall & !exe_branch_taken;

  // pipeline control decoded from the sequencing state and current hazards
  always_comb begin
    pc_en        = (state == RUN) ? (exe_branch_taken | !stall) : (state == DRAIN) & exe_branch_taken;
    if_id_en     = (state != HALTED) & !stall;
    if_id_flush  = (state == DRAIN) | ((state == RUN) & exe_branch_taken);
    id_exe_flush = (state == HALTED) | stall | exe_branch_taken;
    halted       = state == HALTED;
  end

  // halt/drain sequencer; drain counter only advances on non-stalled cycles
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: if (halt_req) begin
          state <= DRAIN;
          cnt   <= 3'(DRAIN_CYCLES);
        end
        DRAIN: if (!stall_eff) begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= HALTED;
        end
        HALTED: if (!halt_req) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of stall, flush, forwarding and halt-drain behaviour
module tb_hazard_ctrl;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] id_rs, id_rt, exe_rs, exe_rt, exe_rd, mem_rd, wb_rd;
  logic       id_rs_used, id_rt_used, exe_reg_write, exe_mem_read, exe_branch_taken;
  logic       mem_reg_write, wb_reg_write, halt_req;
  logic       pc_en, if_id_en, if_id_flush, id_exe_flush, halted;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [4:0] ctl;
  int         total = 0;
  int         bad = 0;
`ifdef HAZ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [4:0] C_RUN = 5'b11000, C_STALL = 5'b00010, C_DRAIN = 5'b01100, C_HALT = 5'b00011;

  hazard_ctrl dut (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .exe_rs(exe_rs), .exe_rt(exe_rt), .exe_rd(exe_rd),
    .exe_reg_write(exe_reg_write), .exe_mem_read(exe_mem_read), .exe_branch_taken(exe_branch_taken),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .halt_req(halt_req), .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_exe_flush(id_exe_flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .halted(halted)
  );

  assign ctl = {pc_en, if_id_en, if_id_flush, id_exe_flush, halted};

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    {id_rs, id_rt, exe_rs, exe_rt, exe_rd, mem_rd, wb_rd} = '0;
    {id_rs_used, id_rt_used, exe_reg_write, exe_mem_read, exe_branch_taken} = '0;
    {mem_reg_write, wb_reg_write, halt_req} = '0;
  endtask

  task automatic load_use();
    id_rs = 3'd3; id_rs_used = 1'b1; exe_rd = 3'd3; exe_mem_read = 1'b1; exe_reg_write = 1'b1;
  endtask

  int         kind [7] = '{0, 1, 2, 0, 0, 0, 0};
  logic [4:0] dexp [7] = '{C_DRAIN, 5'b00110, 5'b11110, C_DRAIN, C_DRAIN, C_HALT, C_HALT};

  initial begin
    idle();
    @(negedge clock); #1;
    check("rst_ctl", 8'(ctl), 8'(C_RUN));
    check("rst_fwd", {4'd0, fwd_a_sel, fwd_b_sel}, 8'h00);
    reset = 1'b1;
    @(negedge clock); idle(); load_use(); #1;
    check("lu_stall", 8'(ctl), 8'(C_STALL));
    @(negedge clock); idle(); exe_rs = 3'd3; mem_rd = 3'd3; mem_reg_write = 1'b1; #1;
    check("lu_after", 8'(ctl), 8'(C_RUN));
    check("lu_fwd_a", 8'(fwd_a_sel), FWD ? 8'h01 : 8'h00);
    @(negedge clock); idle(); exe_rt = 3'd5; mem_rd = 3'd5; wb_rd = 3'd5; mem_reg_write = 1'b1; wb_reg_write = 1'b1; #1;
    check("fb_mem", 8'(fwd_b_sel), FWD ? 8'h01 : 8'h00);
    check("fa_idle", 8'(fwd_a_sel), 8'h00);
    mem_reg_write = 1'b0; #1;
    check("fb_wb", 8'(fwd_b_sel), FWD ? 8'h02 : 8'h00);
    exe_rt = 3'd0; mem_rd = 3'd0; wb_rd = 3'd0; mem_reg_write = 1'b1; #1;
    check("fb_r0", 8'(fwd_b_sel), 8'h00);
    exe_rs = 3'd5; wb_rd = 3'd5; mem_reg_write = 1'b0; #1;
    check("fa_wb", 8'(fwd_a_sel), FWD ? 8'h02 : 8'h00);
    @(negedge clock); idle(); load_use(); exe_branch_taken = 1'b1; #1;
    check("br_stall", 8'({pc_en, if_id_flush, id_exe_flush, halted}), 8'h0e);
    @(negedge clock); idle(); id_rs = 3'd0; id_rs_used = 1'b1; exe_rd = 3'd0; exe_reg_write = 1'b1; exe_mem_read = 1'b1; #1;
    check("r0_nostall", 8'(ctl), 8'(C_RUN));
    @(negedge clock); idle(); id_rt = 3'd2; id_rt_used = 1'b1; mem_rd = 3'd2; mem_reg_write = 1'b1; #1;
    check("mem_dep", 8'(ctl), 8'(FWD ? C_RUN : C_STALL));
    @(negedge clock); idle(); id_rs = 3'd2; id_rs_used = 1'b1; exe_rd = 3'd2; exe_reg_write = 1'b1; #1;
    check("exe_dep1", 8'(ctl), 8'(FWD ? C_RUN : C_STALL));
    @(negedge clock); idle(); id_rs = 3'd2; id_rs_used = 1'b1; mem_rd = 3'd2; mem_reg_write = 1'b1; #1;
    check("exe_dep2", 8'(ctl), 8'(FWD ? C_RUN : C_STALL));
    @(negedge clock); idle(); id_rs = 3'd2; id_rs_used = 1'b1; wb_rd = 3'd2; wb_reg_write = 1'b1; #1;
    check("wb_dep", 8'(ctl), 8'(C_RUN));
    @(negedge clock); idle(); halt_req = 1'b1; #1;
    check("halt_req", 8'(ctl), 8'(C_RUN));
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); idle(); #1;
      check($sformatf("drain%0d", i), 8'(ctl), 8'(C_DRAIN));
    end
    @(negedge clock); #1;
    check("halted", 8'(ctl), 8'(C_HALT));
    @(negedge clock); #1;
    check("resume", 8'(ctl), 8'(C_RUN));
    @(negedge clock); idle(); halt_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock); idle(); halt_req = (i < 6);
      if (kind[i] == 1) load_use();
      if (kind[i] == 2) exe_branch_taken = 1'b1;
      #1;
      check($sformatf("dseq%0d", i), 8'(ctl), 8'(dexp[i]));
    end
    @(negedge clock); idle(); #1;
    check("dseq_run", 8'(ctl), 8'(C_RUN));
    @(negedge clock); idle(); halt_req = 1'b1;
    @(negedge clock); idle(); #1;
    check("rd_drain1", 8'(ctl), 8'(C_DRAIN));
    @(negedge clock); #1;
    check("rd_drain2", 8'(ctl), 8'(C_DRAIN));
    reset = 1'b0; #1;
    check("rd_async", 8'(ctl), 8'(C_RUN));
    @(negedge clock); reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock); #1;
      check($sformatf("rd_run%0d", i), 8'(ctl), 8'(C_RUN));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
